// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: widths, opcodes and the fetch queue entry.
package mips_pkg;

  localparam int WORD = 32;
  localparam int OPC  = 6;

  localparam logic [OPC-1:0] OPC_RTYPE = 6'b000000;
  localparam logic [OPC-1:0] OPC_ADDI  = 6'b001000;
  localparam logic [OPC-1:0] OPC_ANDI  = 6'b001100;
  localparam logic [OPC-1:0] OPC_LW    = 6'b100011;
  localparam logic [OPC-1:0] OPC_SW    = 6'b101011;

  localparam logic [WORD-1:0] NOP_WORD = 32'h0000_0000;

  typedef struct packed {
    logic [WORD-1:0] instr;
    logic [WORD-1:0] pc4;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// In-order FIFO of fetched words paired with their PC+4; flush empties it.
module fetch_queue
  import mips_pkg::*;
#(
  parameter int QDEPTH = 2,
  localparam int CW = $clog2(QDEPTH) + 1
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         flush,
  input  logic         push,
  input  logic         pop,
  input  fetch_entry_t push_data,
  output fetch_entry_t head,
  output logic [CW-1:0] count,
  output logic         empty
);

  localparam int PW = $clog2(QDEPTH);

  fetch_entry_t mem [QDEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  assign head  = mem[rd_ptr];
  assign empty = (count == '0);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  // Pointers wrap naturally because QDEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!reset_n || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      assert (!(push && !pop && (count == CW'(QDEPTH))));
      assert (!(pop && (count == '0)));
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// IF stage: PC, credit-limited fetch to instruction memory, in-order return
// queue and the IF/ID register with stall and redirect handling.
module instr_fetch_unit
  import mips_pkg::*;
#(
  parameter logic [WORD-1:0] PC_RESET = 32'h0000_0000,
  parameter int              QDEPTH   = 2
) (
  input  logic            clk,
  input  logic            reset_n,
  output logic            imem_req,
  output logic [WORD-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic            imem_rvalid,
  input  logic [WORD-1:0] imem_rdata,
  input  logic            stall,
  input  logic            redirect,
  input  logic [WORD-1:0] redirect_pc,
  output logic            if_valid,
  output logic [WORD-1:0] if_instr,
  output logic [OPC-1:0]  if_opcode,
  output logic [WORD-1:0] if_pc4
);

  localparam int CW = $clog2(QDEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(QDEPTH);

  logic [WORD-1:0] pc;
  logic [WORD-1:0] resp_pc4;
  logic [WORD-1:0] target;
  logic [CW-1:0]   outstanding;
  logic [CW-1:0]   drop;
  logic [CW-1:0]   q_count;
  logic            q_empty;
  fetch_entry_t    q_head;
  fetch_entry_t    q_in;
  logic            issue, accept, drop_dec, load_ifid, pop, push, bypass;

  // A request may only go out if its response is guaranteed a queue slot.
  assign imem_req  = reset_n && !redirect && ((outstanding + q_count) < DEPTH_C);
  assign imem_addr = pc;
  assign issue     = imem_req && imem_ready;
  assign accept    = imem_rvalid && (drop == '0);
  assign drop_dec  = imem_rvalid && (drop != '0);
  assign load_ifid = !stall && !redirect;
  assign pop       = load_ifid && !q_empty;
  assign bypass    = load_ifid && q_empty && accept;
  assign push      = accept && !bypass && !redirect;
  assign target    = redirect_pc & ~32'h3;
  assign q_in      = '{instr: imem_rdata, pc4: resp_pc4};
  assign if_opcode = if_instr[WORD-1 -: OPC];

  fetch_queue #(.QDEPTH(QDEPTH)) u_queue (
    .clk       (clk),
    .reset_n   (reset_n),
    .flush     (redirect),
    .push      (push),
    .pop       (pop),
    .push_data (q_in),
    .head      (q_head),
    .count     (q_count),
    .empty     (q_empty)
  );

  // Requests still in flight at a redirect become drop credits for stale data.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pc          <= PC_RESET;
      resp_pc4    <= PC_RESET + 32'd4;
      outstanding <= '0;
      drop        <= '0;
    end else if (redirect) begin
      pc          <= target;
      resp_pc4    <= target + 32'd4;
      outstanding <= '0;
      drop        <= drop - CW'(drop_dec) + outstanding + CW'(issue) - CW'(accept);
    end else begin
      if (issue)  pc       <= pc + 32'd4;
      if (accept) resp_pc4 <= resp_pc4 + 32'd4;
      outstanding <= outstanding + CW'(issue) - CW'(accept);
      drop        <= drop - CW'(drop_dec);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      if_valid <= 1'b0;
      if_instr <= NOP_WORD;
      if_pc4   <= '0;
    end else if (redirect) begin
      if_valid <= 1'b0;
      if_instr <= NOP_WORD;
    end else if (!stall) begin
      if (!q_empty) begin
        if_valid <= 1'b1;
        if_instr <= q_head.instr;
        if_pc4   <= q_head.pc4;
      end else if (accept) begin
        if_valid <= 1'b1;
        if_instr <= imem_rdata;
        if_pc4   <= resp_pc4;
      end else begin
        if_valid <= 1'b0;
        if_instr <= NOP_WORD;
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with an in-order instruction memory model.
module tb_instr_fetch_unit;
  import mips_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        imem_req, imem_ready, imem_rvalid;
  logic [31:0] imem_addr, imem_rdata;
  logic        stall, redirect;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic [31:0] if_instr, if_pc4;
  logic [5:0]  if_opcode;

  logic        b_req, b_rvalid, b_valid;
  logic [31:0] b_addr, b_rdata, b_instr, b_pc4;
  logic [5:0]  b_opcode;
  logic        b_ready = 1'b1;
  logic        b_stall = 1'b0;
  logic        b_redirect = 1'b0;
  logic [31:0] b_redirect_pc = 32'h0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int lat_min = 1;
  int lat_max = 1;
  bit rand_ready = 1'b0;
  int last_due = -1;
  logic [31:0] pend_addr[$];
  int          pend_due[$];

  instr_fetch_unit #(.PC_RESET(32'h0000_0000), .QDEPTH(2)) dut (
    .clk(clk), .reset_n(reset_n), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .if_valid(if_valid), .if_instr(if_instr), .if_opcode(if_opcode), .if_pc4(if_pc4)
  );

  instr_fetch_unit #(.PC_RESET(32'hFFFF_FFF8), .QDEPTH(2)) dut_wrap (
    .clk(clk), .reset_n(reset_n), .imem_req(b_req), .imem_addr(b_addr),
    .imem_ready(b_ready), .imem_rvalid(b_rvalid), .imem_rdata(b_rdata),
    .stall(b_stall), .redirect(b_redirect), .redirect_pc(b_redirect_pc),
    .if_valid(b_valid), .if_instr(b_instr), .if_opcode(b_opcode), .if_pc4(b_pc4)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // One clock: sample issues before the edge, then update both memory models.
  task automatic tick();
    logic        iss, iss2;
    logic [31:0] a, a2;
    int          d;
    #1;
    iss  = imem_req && imem_ready;
    a    = imem_addr;
    iss2 = b_req;
    a2   = b_addr;
    @(posedge clk);
    #1;
    cyc++;
    if (iss) begin
      d = cyc + int'($urandom_range(lat_max, lat_min)) - 1;
      if (d <= last_due) d = last_due + 1;
      last_due = d;
      pend_addr.push_back(a);
      pend_due.push_back(d);
    end
    if (pend_due.size() > 0 && pend_due[0] <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = pend_addr.pop_front() | 32'h2000_0000;
      void'(pend_due.pop_front());
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = 32'hDEAD_BEEF;
    end
    imem_ready = rand_ready ? 1'($urandom_range(1, 0)) : 1'b1;
    b_rvalid   = iss2;
    b_rdata    = a2 | 32'h2000_0000;
  endtask

  initial begin
    bit          found;
    bit          st;
    int          nvalid;
    logic [31:0] exp_pc4;

    reset_n = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    imem_ready = 1'b1; imem_rvalid = 1'b0; imem_rdata = 32'h0;
    b_rvalid = 1'b0; b_rdata = 32'h0;

    tick();
    check("reset_req_low", imem_req, 1'b0);
    check("reset_valid", if_valid, 1'b0);
    tick();
    reset_n = 1'b1;
    #1;
    check("c0_valid", if_valid, 1'b0);
    check("c0_instr", if_instr, 32'h0);
    check("c0_pc4", if_pc4, 32'h0);
    check("c0_req", imem_req, 1'b1);
    check("c0_addr", imem_addr, 32'h0);
    check("wrap_c0_addr", b_addr, 32'hFFFF_FFF8);

    tick();
    check("c1_valid", if_valid, 1'b0);
    check("c1_addr", imem_addr, 32'h4);
    check("wrap_c1_addr", b_addr, 32'hFFFF_FFFC);

    tick();
    check("first_valid", if_valid, 1'b1);
    check("first_instr", if_instr, 32'h2000_0000);
    check("first_pc4", if_pc4, 32'h4);
    check("first_opcode", {26'h0, if_opcode}, {26'h0, OPC_ADDI});
    check("wrap_c2_addr", b_addr, 32'h0);
    check("wrap_c2_pc4", b_pc4, 32'hFFFF_FFFC);

    stall = 1'b1;
    tick();
    check("stall_c3_pc4", if_pc4, 32'h4);
    check("stall_c3_req", imem_req, 1'b0);
    check("wrap_c3_pc4", b_pc4, 32'h0);
    check("wrap_c3_addr", b_addr, 32'h4);
    tick();
    check("stall_c4_valid", if_valid, 1'b1);
    check("stall_c4_req", imem_req, 1'b0);
    check("wrap_c4_pc4", b_pc4, 32'h4);
    tick();
    tick();
    check("stall_c6_pc4", if_pc4, 32'h4);
    check("stall_c6_instr", if_instr, 32'h2000_0000);
    stall = 1'b0;
    tick();
    check("release_w4_pc4", if_pc4, 32'h8);
    check("release_w4_instr", if_instr, 32'h2000_0004);
    tick();
    check("release_w8_pc4", if_pc4, 32'hC);
    check("release_w8_instr", if_instr, 32'h2000_0008);
    tick();
    check("release_w12_pc4", if_pc4, 32'h10);

    lat_min = 3; lat_max = 3;
    tick();
    check("slow_w16_pc4", if_pc4, 32'h14);
    tick();
    check("inflight_req_low", imem_req, 1'b0);
    redirect = 1'b1; redirect_pc = 32'h0000_0043;
    #1;
    check("redirect_req_low", imem_req, 1'b0);
    lat_min = 1; lat_max = 1;
    tick();
    redirect = 1'b0;
    #1;
    check("redirect_valid", if_valid, 1'b0);
    check("redirect_instr", if_instr, 32'h0);
    check("redirect_addr", imem_addr, 32'h40);
    check("redirect_req", imem_req, 1'b1);
    found = 1'b0;
    for (int i = 0; i < 12 && !found; i++) begin
      tick();
      if (if_valid) found = 1'b1;
    end
    check("redirect_found", found, 1'b1);
    check("redirect_pc4", if_pc4, 32'h44);
    check("redirect_instr_new", if_instr, 32'h2000_0040);

    stall = 1'b1; redirect = 1'b1; redirect_pc = 32'h0000_0100;
    tick();
    stall = 1'b0; redirect = 1'b0;
    #1;
    check("redir_stall_valid", if_valid, 1'b0);
    check("redir_stall_instr", if_instr, 32'h0);
    check("redir_stall_addr", imem_addr, 32'h100);
    found = 1'b0;
    for (int i = 0; i < 12 && !found; i++) begin
      tick();
      if (if_valid) found = 1'b1;
    end
    check("redir_stall_found", found, 1'b1);
    check("redir_stall_pc4", if_pc4, 32'h104);

    rand_ready = 1'b1; lat_min = 1; lat_max = 4;
    exp_pc4 = 32'h108;
    nvalid = 0;
    for (int i = 0; i < 300; i++) begin
      stall = ($urandom_range(3, 0) == 0);
      st = stall;
      tick();
      if (!st && if_valid) begin
        check("rand_pc4", if_pc4, exp_pc4);
        check("rand_instr", if_instr, (exp_pc4 - 32'd4) | 32'h2000_0000);
        exp_pc4 = exp_pc4 + 32'd4;
        nvalid++;
      end
    end
    stall = 1'b0;
    check("rand_progress", nvalid > 20, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
